// File: rtl/bg_scroll_engine.sv
// Scaled, horizontally scrolling, paged background pixel pipeline with an internal
// image store and a writable palette. Define BG_SCROLL_EN to enable per-frame scrolling.
module bg_scroll_engine #(
  parameter int unsigned IMG_W     = 400,
  parameter int unsigned IMG_H     = 300,
  parameter int unsigned SCALE_NUM = 5,
  parameter int unsigned SCALE_DEN = 8,
  parameter int unsigned NUM_PAGES = 2,
  parameter int unsigned PIX_W     = 4,
  parameter logic [3:0]  BG_STATUS = 4'b0001,
  localparam int unsigned PAGE_W   = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int unsigned ADDR_W   = $clog2(NUM_PAGES * IMG_W * IMG_H)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [3:0]        status,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [7:0]        scroll_step,
  input  logic [PAGE_W-1:0] page_sel,
  input  logic              pal_we,
  input  logic [PIX_W-1:0]  pal_idx,
  input  logic [23:0]       pal_rgb,
  input  logic              img_we,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [PIX_W-1:0]  img_data,
  output logic              is_background,
  output logic [23:0]       color_output,
  output logic [ADDR_W-1:0] background_address
);

  localparam int unsigned SHIFT  = $clog2(SCALE_DEN);
  localparam int unsigned PROD_W = 10 + $clog2(SCALE_NUM + 1);
  localparam int unsigned XW     = $clog2(IMG_W);
  localparam int unsigned MEM_D  = NUM_PAGES * IMG_W * IMG_H;
  localparam int unsigned PAL_N  = 2 ** PIX_W;

  // Screen-to-image scaling at full product width, then divide by the power-of-two denominator
  logic [PROD_W-1:0] w_xs;
  logic [PROD_W-1:0] w_ys;
  logic              w_flag;

  assign w_xs   = (PROD_W'(DrawX) * PROD_W'(SCALE_NUM)) >> SHIFT;
  assign w_ys   = (PROD_W'(DrawY) * PROD_W'(SCALE_NUM)) >> SHIFT;
  assign w_flag = (status == BG_STATUS) && (w_ys < PROD_W'(IMG_H)) && (w_xs < PROD_W'(IMG_W));

  logic [XW-1:0] w_scroll_off;

`ifdef BG_SCROLL_EN
  logic [XW-1:0] r_scroll_off;
  int            w_step_rem;
  logic [XW-1:0] w_step_mod;
  logic [XW:0]   w_scroll_sum;
  logic [XW-1:0] w_scroll_next;

  // Reduce the signed step into 0..IMG_W-1 so one conditional subtract wraps the sum
  always_comb begin
    w_step_rem = int'($signed(scroll_step)) % int'(IMG_W);
    if (w_step_rem < 0) w_step_rem = w_step_rem + int'(IMG_W);
    w_step_mod    = XW'(w_step_rem);
    w_scroll_sum  = (XW+1)'(r_scroll_off) + (XW+1)'(w_step_mod);
    w_scroll_next = (w_scroll_sum >= (XW+1)'(IMG_W)) ? XW'(w_scroll_sum - (XW+1)'(IMG_W))
                                                     : XW'(w_scroll_sum);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         r_scroll_off <= '0;
    else if (frame_start) r_scroll_off <= w_scroll_next;
  end

  assign w_scroll_off = r_scroll_off;
`else
  logic w_unused_step;
  assign w_unused_step = ^scroll_step;
  assign w_scroll_off  = '0;
`endif

  // Active page changes only at a frame boundary and only to an existing page
  logic [PAGE_W-1:0] r_page;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_page <= '0;
    else if (frame_start && ((PAGE_W+1)'(page_sel) < (PAGE_W+1)'(NUM_PAGES))) r_page <= page_sel;
  end

  logic [XW:0]       w_xsum;
  logic [XW-1:0]     w_xw;
  logic [ADDR_W-1:0] w_addr;

  assign w_xsum = (XW+1)'(w_xs) + (XW+1)'(w_scroll_off);
  assign w_xw   = (w_xsum >= (XW+1)'(IMG_W)) ? XW'(w_xsum - (XW+1)'(IMG_W)) : XW'(w_xsum);
  assign w_addr = ADDR_W'(r_page) * ADDR_W'(IMG_W * IMG_H)
                + ADDR_W'(w_ys) * ADDR_W'(IMG_W) + ADDR_W'(w_xw);

  logic              r_flag1;
  logic [ADDR_W-1:0] r_addr1;
  logic              r_flag2;
  logic [ADDR_W-1:0] r_addr2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_flag1 <= 1'b0;
      r_addr1 <= '0;
      r_flag2 <= 1'b0;
      r_addr2 <= '0;
    end else begin
      r_flag1 <= w_flag;
      r_addr1 <= w_flag ? w_addr : '0;
      r_flag2 <= r_flag1;
      r_addr2 <= r_addr1;
    end
  end

  // Image store: contents survive reset; the load port exists only to fill it
  logic [PIX_W-1:0] r_img [MEM_D];
  logic [PIX_W-1:0] r_pix;

  always_ff @(posedge Clk) begin
    if (img_we) r_img[img_addr] <= img_data;
    r_pix <= r_img[r_addr1];
  end

  function automatic logic [23:0] pal_init(input int idx);
    case (idx)
      0:       return 24'hf80504;
      1:       return 24'h69ddfb;
      2:       return 24'hf9de7a;
      3:       return 24'h796e36;
      4:       return 24'h444123;
      5:       return 24'h807029;
      6:       return 24'h2f2c1a;
      default: return 24'h000000;
    endcase
  endfunction

  logic [23:0] r_pal [PAL_N];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(PAL_N); i++) r_pal[i] <= pal_init(i);
    end else if (pal_we) begin
      r_pal[pal_idx] <= pal_rgb;
    end
  end

  // Palette lookup and output register; all three outputs stay aligned to one pixel
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_background      <= 1'b0;
      color_output       <= 24'h000000;
      background_address <= '0;
    end else begin
      is_background      <= r_flag2;
      color_output       <= r_flag2 ? r_pal[r_pix] : 24'h000000;
      background_address <= r_addr2;
    end
  end

endmodule

// File: tb/tb_bg_scroll_engine.sv
// Directed self-checking bench for bg_scroll_engine (default parameters).
module tb_bg_scroll_engine;

  localparam int unsigned ADDR_W = 18;
`ifdef BG_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic              Clk;
  logic              Reset_n;
  logic [3:0]        status;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic [7:0]        scroll_step;
  logic [0:0]        page_sel;
  logic              pal_we;
  logic [3:0]        pal_idx;
  logic [23:0]       pal_rgb;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic [3:0]        img_data;
  logic              is_background;
  logic [23:0]       color_output;
  logic [ADDR_W-1:0] background_address;

  int n_checks = 0;
  int n_pass   = 0;

  bg_scroll_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .status(status), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .scroll_step(scroll_step), .page_sel(page_sel),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .is_background(is_background), .color_output(color_output),
    .background_address(background_address)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_pixel(input logic [3:0] st, input logic [9:0] x, input logic [9:0] y);
    @(negedge Clk);
    status = st; DrawX = x; DrawY = y;
  endtask

  task automatic img_write(input logic [ADDR_W-1:0] a, input logic [3:0] d);
    @(negedge Clk);
    img_we = 1'b1; img_addr = a; img_data = d;
    @(negedge Clk);
    img_we = 1'b0;
  endtask

  task automatic pulse_frame(input logic [7:0] step, input logic [0:0] pg);
    @(negedge Clk);
    frame_start = 1'b1; scroll_step = step; page_sel = pg;
    @(negedge Clk);
    frame_start = 1'b0; scroll_step = 8'd0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    status = 4'd0; DrawX = '0; DrawY = '0; frame_start = 1'b0; scroll_step = '0;
    page_sel = '0; pal_we = 1'b0; pal_idx = '0; pal_rgb = '0;
    img_we = 1'b0; img_addr = '0; img_data = '0;
    #22;
    n_checks++; if (is_background !== 1'b0) $display("FAIL reset_isbg: got %b expected 0", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'h0) $display("FAIL reset_color: got %h expected 000000", color_output); else n_pass++;
    n_checks++; if (background_address !== 18'd0) $display("FAIL reset_addr: got %0d expected 0", background_address); else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic load_image();
    img_write(18'd0,      4'd0);
    img_write(18'd50,     4'd1);
    img_write(18'd399,    4'd2);
    img_write(18'd2004,   4'd4);
    img_write(18'd2005,   4'd3);
    img_write(18'd122005, 4'd6);
  endtask

  task automatic test_basic();
    set_pixel(4'b0001, 10'd8, 10'd8);
    tick(3);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL basic_addr: got %0d expected 2005", background_address); else n_pass++;
    n_checks++; if (is_background !== 1'b1) $display("FAIL basic_isbg: got %b expected 1", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'h796e36) $display("FAIL basic_color: got %h expected 796e36", color_output); else n_pass++;
  endtask

  task automatic test_latency();
    set_pixel(4'b0001, 10'd0, 10'd0);
    tick(2);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL latency_early: got %0d expected 2005", background_address); else n_pass++;
    tick(1);
    n_checks++; if (background_address !== 18'd0) $display("FAIL latency_addr: got %0d expected 0", background_address); else n_pass++;
    n_checks++; if (is_background !== 1'b1) $display("FAIL latency_isbg: got %b expected 1", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'hf80504) $display("FAIL latency_color: got %h expected f80504", color_output); else n_pass++;
  endtask

  task automatic test_range();
    set_pixel(4'b0010, 10'd8, 10'd8);
    tick(3);
    n_checks++; if (is_background !== 1'b0) $display("FAIL status_isbg: got %b expected 0", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'h0) $display("FAIL status_color: got %h expected 000000", color_output); else n_pass++;
    n_checks++; if (background_address !== 18'd0) $display("FAIL status_addr: got %0d expected 0", background_address); else n_pass++;
    set_pixel(4'b0001, 10'd8, 10'd480);
    tick(3);
    n_checks++; if (is_background !== 1'b0) $display("FAIL ybound_isbg: got %b expected 0", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'h0) $display("FAIL ybound_color: got %h expected 000000", color_output); else n_pass++;
    n_checks++; if (background_address !== 18'd0) $display("FAIL ybound_addr: got %0d expected 0", background_address); else n_pass++;
    set_pixel(4'b0001, 10'd640, 10'd0);
    tick(3);
    n_checks++; if (is_background !== 1'b0) $display("FAIL xbound_isbg: got %b expected 0", is_background); else n_pass++;
    set_pixel(4'b0001, 10'd639, 10'd0);
    tick(3);
    n_checks++; if (background_address !== 18'd399) $display("FAIL xedge_addr: got %0d expected 399", background_address); else n_pass++;
    n_checks++; if (color_output !== 24'hf9de7a) $display("FAIL xedge_color: got %h expected f9de7a", color_output); else n_pass++;
  endtask

  task automatic test_page();
    set_pixel(4'b0001, 10'd8, 10'd8);
    page_sel = 1'b1;
    tick(3);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL page_hold: got %0d expected 2005", background_address); else n_pass++;
    pulse_frame(8'd0, 1'b1);
    tick(3);
    n_checks++; if (background_address !== 18'd122005) $display("FAIL page1_addr: got %0d expected 122005", background_address); else n_pass++;
    n_checks++; if (color_output !== 24'h2f2c1a) $display("FAIL page1_color: got %h expected 2f2c1a", color_output); else n_pass++;
    pulse_frame(8'd0, 1'b0);
    tick(3);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL page0_addr: got %0d expected 2005", background_address); else n_pass++;
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 45; i++) pulse_frame(8'd10, 1'b0);
    set_pixel(4'b0001, 10'd0, 10'd0);
    tick(3);
    n_checks++; if (background_address !== (SCROLL ? 18'd50 : 18'd0)) $display("FAIL scroll50_addr: got %0d expected %0d", background_address, SCROLL ? 50 : 0); else n_pass++;
    n_checks++; if (color_output !== (SCROLL ? 24'h69ddfb : 24'hf80504)) $display("FAIL scroll50_color: got %h", color_output); else n_pass++;
    pulse_frame(8'hCE, 1'b0);
    tick(3);
    n_checks++; if (background_address !== 18'd0) $display("FAIL scroll0_addr: got %0d expected 0", background_address); else n_pass++;
    pulse_frame(8'hFF, 1'b0);
    tick(3);
    n_checks++; if (background_address !== (SCROLL ? 18'd399 : 18'd0)) $display("FAIL scrollneg_addr: got %0d expected %0d", background_address, SCROLL ? 399 : 0); else n_pass++;
    n_checks++; if (color_output !== (SCROLL ? 24'hf9de7a : 24'hf80504)) $display("FAIL scrollneg_color: got %h", color_output); else n_pass++;
    set_pixel(4'b0001, 10'd8, 10'd8);
    tick(3);
    n_checks++; if (background_address !== (SCROLL ? 18'd2004 : 18'd2005)) $display("FAIL scrollwrap_addr: got %0d expected %0d", background_address, SCROLL ? 2004 : 2005); else n_pass++;
    n_checks++; if (color_output !== (SCROLL ? 24'h444123 : 24'h796e36)) $display("FAIL scrollwrap_color: got %h", color_output); else n_pass++;
    pulse_frame(8'd1, 1'b0);
    tick(3);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL scrollback_addr: got %0d expected 2005", background_address); else n_pass++;
  endtask

  task automatic test_palette();
    set_pixel(4'b0001, 10'd0, 10'd0);
    tick(3);
    @(negedge Clk);
    pal_we = 1'b1; pal_idx = 4'd0; pal_rgb = 24'h00ff00;
    tick(1);
    n_checks++; if (color_output !== 24'hf80504) $display("FAIL pal_same_cycle: got %h expected f80504", color_output); else n_pass++;
    @(negedge Clk);
    pal_we = 1'b0;
    tick(1);
    n_checks++; if (color_output !== 24'h00ff00) $display("FAIL pal_next: got %h expected 00ff00", color_output); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (is_background !== 1'b0) $display("FAIL areset_isbg: got %b expected 0", is_background); else n_pass++;
    n_checks++; if (color_output !== 24'h0) $display("FAIL areset_color: got %h expected 000000", color_output); else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick(3);
    n_checks++; if (color_output !== 24'hf80504) $display("FAIL areset_pal0: got %h expected f80504", color_output); else n_pass++;
    set_pixel(4'b0001, 10'd8, 10'd8);
    tick(3);
    n_checks++; if (background_address !== 18'd2005) $display("FAIL areset_addr: got %0d expected 2005", background_address); else n_pass++;
    n_checks++; if (color_output !== 24'h796e36) $display("FAIL areset_img: got %h expected 796e36", color_output); else n_pass++;
  endtask

  initial begin
    test_reset();
    load_image();
    test_basic();
    test_latency();
    test_range();
    test_page();
    test_scroll();
    test_palette();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
